// File: rtl/reg_file_hilo.sv
// Decode-stage register file with a HI/LO pair owned by a multi-cycle mult/div unit while it is BUSY.
// Reads have zero latency (combinational). Writes commit at the next rising CLK edge.
// stall is raised while port A reads HI/LO during BUSY; hilo_wready accepts a result only in BUSY.
module reg_file_hilo #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    input  logic [1:0]        rs_sel,
    input  logic              regWrite,
    input  logic [1:0]        w_sel,
    input  logic [ADDR_W-1:0] WAddr,
    input  logic [DATA_W-1:0] WData,
    input  logic              hilo_issue,
    input  logic              hilo_wvalid,
    input  logic [DATA_W-1:0] Whi,
    input  logic [DATA_W-1:0] Wlo,
    output logic              hilo_wready,
    output logic [DATA_W-1:0] rsData,
    output logic [DATA_W-1:0] rtData,
    output logic              hilo_busy,
    output logic              stall,
    output logic              hilo_err
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [DATA_W-1:0] gpr [DEPTH];
    logic [DATA_W-1:0] hi, lo;
    logic [0:0]        state, state_nxt;
    logic              err;

    logic busy, complete, gpr_we, mt_hi, mt_lo, hi_we_mt, lo_we_mt, err_set;
    logic [DATA_W-1:0] rs_gpr, rt_gpr, hi_rd, lo_rd;

    assign busy     = (state == BUSY);
    assign complete = busy & hilo_wvalid;
    assign gpr_we   = regWrite & (w_sel == 2'b00) & ~((ZERO_REG != 0) && (WAddr == '0));
    assign mt_hi    = regWrite & (w_sel == 2'b01);
    assign mt_lo    = regWrite & (w_sel == 2'b10);
    // HI/LO belong to the mult/div unit while BUSY, so mthi/mtlo only land in IDLE
    assign hi_we_mt = mt_hi & ~busy;
    assign lo_we_mt = mt_lo & ~busy;
    assign err_set  = (~busy & hilo_wvalid)
                    | (busy & hilo_issue & ~hilo_wvalid)
                    | (busy & (mt_hi | mt_lo));

    assign hilo_busy   = busy;
    assign hilo_wready = busy;
    assign hilo_err    = err;
    assign stall       = busy & ((rs_sel == 2'b01) | (rs_sel == 2'b10))
                       & ~(hilo_wvalid & (BYPASS != 0));

    always_comb begin
        state_nxt = state;
        if (state == IDLE) begin
            if (hilo_issue) state_nxt = BUSY;
        end else if (hilo_wvalid) begin
            state_nxt = hilo_issue ? BUSY : IDLE;
        end
    end

    always_comb begin
        rs_gpr = gpr[rs];
        rt_gpr = gpr[rt];
        hi_rd  = hi;
        lo_rd  = lo;
        if (BYPASS != 0) begin
            if (gpr_we && (WAddr == rs)) rs_gpr = WData;
            if (gpr_we && (WAddr == rt)) rt_gpr = WData;
            if (complete) begin
                hi_rd = Whi;
                lo_rd = Wlo;
            end else begin
                if (hi_we_mt) hi_rd = WData;
                if (lo_we_mt) lo_rd = WData;
            end
        end
        if ((ZERO_REG != 0) && (rs == '0)) rs_gpr = '0;
        if ((ZERO_REG != 0) && (rt == '0)) rt_gpr = '0;

        case (rs_sel)
            2'b01:   rsData = hi_rd;
            2'b10:   rsData = lo_rd;
            default: rsData = rs_gpr;
        endcase
        rtData = rt_gpr;
        // Keep outputs quiet while reset is held, even if write inputs would bypass
        if (!RST_N) begin
            rsData = '0;
            rtData = '0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < DEPTH; i++) gpr[i] <= '0;
            hi    <= '0;
            lo    <= '0;
            state <= IDLE;
            err   <= 1'b0;
        end else begin
            if (gpr_we) gpr[WAddr] <= WData;
            if (complete) begin
                hi <= Whi;
                lo <= Wlo;
            end else begin
                if (hi_we_mt) hi <= WData;
                if (lo_we_mt) lo <= WData;
            end
            state <= state_nxt;
            if (err_set) err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_reg_file_hilo.sv
// Directed bench for reg_file_hilo: a bypassing instance and a non-bypassing instance share all inputs.
module tb_reg_file_hilo;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [4:0]  rs, rt, WAddr;
    logic [1:0]  rs_sel, w_sel;
    logic        regWrite, hilo_issue, hilo_wvalid;
    logic [31:0] WData, Whi, Wlo;

    logic        hilo_wready, hilo_busy, stall, hilo_err;
    logic [31:0] rsData, rtData;
    logic        hilo_wready_nb, hilo_busy_nb, stall_nb, hilo_err_nb;
    logic [31:0] rsData_nb, rtData_nb;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 CLK = ~CLK;

    reg_file_hilo #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) dut (
        .CLK(CLK), .RST_N(RST_N), .rs(rs), .rt(rt), .rs_sel(rs_sel),
        .regWrite(regWrite), .w_sel(w_sel), .WAddr(WAddr), .WData(WData),
        .hilo_issue(hilo_issue), .hilo_wvalid(hilo_wvalid), .Whi(Whi), .Wlo(Wlo),
        .hilo_wready(hilo_wready), .rsData(rsData), .rtData(rtData),
        .hilo_busy(hilo_busy), .stall(stall), .hilo_err(hilo_err)
    );

    reg_file_hilo #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(0)) dut_nb (
        .CLK(CLK), .RST_N(RST_N), .rs(rs), .rt(rt), .rs_sel(rs_sel),
        .regWrite(regWrite), .w_sel(w_sel), .WAddr(WAddr), .WData(WData),
        .hilo_issue(hilo_issue), .hilo_wvalid(hilo_wvalid), .Whi(Whi), .Wlo(Wlo),
        .hilo_wready(hilo_wready_nb), .rsData(rsData_nb), .rtData(rtData_nb),
        .hilo_busy(hilo_busy_nb), .stall(stall_nb), .hilo_err(hilo_err_nb)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge; inputs change there, checks follow at +2
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        RST_N = 1'b0; rs = '0; rt = '0; rs_sel = 2'b00; regWrite = 1'b0; w_sel = 2'b11;
        WAddr = '0; WData = '0; hilo_issue = 1'b0; hilo_wvalid = 1'b0; Whi = '0; Wlo = '0;
        #2;
        chk("rst_rsData", rsData, 32'h0);
        chk("rst_rtData", rtData, 32'h0);
        chk("rst_busy", 32'(hilo_busy), 32'h0);
        chk("rst_wready", 32'(hilo_wready), 32'h0);
        chk("rst_stall", 32'(stall), 32'h0);
        chk("rst_err", 32'(hilo_err), 32'h0);
        step(); step();
        RST_N = 1'b1;

        // GPR write with same-cycle read: bypass vs. array contents
        step();
        regWrite = 1'b1; w_sel = 2'b00; WAddr = 5'd3; WData = 32'hDEADBEEF; rs = 5'd3; rt = 5'd3;
        settle();
        chk("byp_rs3", rsData, 32'hDEADBEEF);
        chk("nobyp_rs3", rsData_nb, 32'h0);
        step();
        WAddr = 5'd0; WData = 32'h00001234; rt = 5'd0;
        settle();
        chk("rd_rs3", rsData, 32'hDEADBEEF);
        chk("rd_rs3_nb", rsData_nb, 32'hDEADBEEF);
        chk("zero_byp_rt0", rtData, 32'h0);
        step();
        regWrite = 1'b0; rs = 5'd0; rt = 5'd3;
        settle();
        chk("zero_rs0", rsData, 32'h0);
        chk("rd_rt3", rtData, 32'hDEADBEEF);

        step();
        regWrite = 1'b1; WAddr = 5'd7; WData = 32'h55AA55AA; rs = 5'd7; rt = 5'd7;
        settle();
        chk("byp_rs7", rsData, 32'h55AA55AA);
        chk("byp_rt7", rtData, 32'h55AA55AA);
        chk("nobyp_rs7", rsData_nb, 32'h0);
        chk("nobyp_rt7", rtData_nb, 32'h0);
        step();
        regWrite = 1'b0;
        settle();
        chk("nb_rs7_after", rsData_nb, 32'h55AA55AA);

        // Issue, three busy cycles, then completion, with port A reading HI throughout
        step();
        hilo_issue = 1'b1; rs_sel = 2'b01;
        settle();
        chk("issue_stall", 32'(stall), 32'h0);
        for (int c = 0; c < 3; c++) begin
            step();
            hilo_issue = 1'b0;
            settle();
            chk("busy_stall", 32'(stall), 32'h1);
        end
        chk("busy_flag", 32'(hilo_busy), 32'h1);
        chk("busy_wready", 32'(hilo_wready), 32'h1);
        step();
        hilo_wvalid = 1'b1; Whi = 32'h1; Wlo = 32'hFFFFFFFE;
        settle();
        chk("cmpl_stall", 32'(stall), 32'h0);
        chk("cmpl_stall_nb", 32'(stall_nb), 32'h1);
        chk("cmpl_byp_hi", rsData, 32'h1);
        step();
        hilo_wvalid = 1'b0;
        settle();
        chk("hi_after", rsData, 32'h1);
        chk("busy_after", 32'(hilo_busy), 32'h0);
        rs_sel = 2'b10;
        settle();
        chk("lo_after", rsData, 32'hFFFFFFFE);
        chk("err_clean", 32'(hilo_err), 32'h0);

        // Back-to-back: completion and new issue in the same cycle
        step();
        hilo_issue = 1'b1;
        step();
        hilo_issue = 1'b0;
        step();
        hilo_wvalid = 1'b1; hilo_issue = 1'b1; Whi = 32'hA0A0A0A0; Wlo = 32'h0B0B0B0B;
        step();
        hilo_wvalid = 1'b0; hilo_issue = 1'b0; rs_sel = 2'b01;
        settle();
        chk("b2b_busy", 32'(hilo_busy), 32'h1);
        chk("b2b_hi", rsData, 32'hA0A0A0A0);
        rs_sel = 2'b10;
        settle();
        chk("b2b_lo", rsData, 32'h0B0B0B0B);
        chk("b2b_err", 32'(hilo_err), 32'h0);

        // mtlo while BUSY is dropped and flagged
        step();
        regWrite = 1'b1; w_sel = 2'b10; WData = 32'h0000CAFE;
        settle();
        chk("mtlo_busy_nobyp", rsData, 32'h0B0B0B0B);
        step();
        regWrite = 1'b0; w_sel = 2'b11;
        settle();
        chk("mtlo_busy_lo", rsData, 32'h0B0B0B0B);
        chk("mtlo_busy_err", 32'(hilo_err), 32'h1);

        // Reset asynchronously while BUSY
        rs_sel = 2'b01;
        settle();
        chk("pre_rst_stall", 32'(stall), 32'h1);
        RST_N = 1'b0;
        #1;
        chk("arst_busy", 32'(hilo_busy), 32'h0);
        chk("arst_stall", 32'(stall), 32'h0);
        chk("arst_err", 32'(hilo_err), 32'h0);
        step();
        RST_N = 1'b1;
        settle();
        chk("arst_hi", rsData, 32'h0);
        rs_sel = 2'b10;
        settle();
        chk("arst_lo", rsData, 32'h0);

        // Stray result in IDLE is refused and flagged
        step();
        hilo_wvalid = 1'b1; Whi = 32'h5; Wlo = 32'h6;
        settle();
        chk("idle_wready", 32'(hilo_wready), 32'h0);
        chk("idle_lo_nobyp", rsData, 32'h0);
        step();
        hilo_wvalid = 1'b0;
        settle();
        chk("idle_lo", rsData, 32'h0);
        chk("idle_err", 32'(hilo_err), 32'h1);
        chk("idle_busy", 32'(hilo_busy), 32'h0);

        // mthi in IDLE writes normally
        step();
        regWrite = 1'b1; w_sel = 2'b01; WData = 32'h00000077; rs_sel = 2'b01;
        settle();
        chk("mthi_byp", rsData, 32'h77);
        chk("mthi_nobyp", rsData_nb, 32'h0);
        step();
        regWrite = 1'b0; w_sel = 2'b11;
        settle();
        chk("mthi_hi", rsData, 32'h77);
        chk("mthi_hi_nb", rsData_nb, 32'h77);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/reg_file_hilo.md
Name: reg_file_hilo

Overview:
Parametrised successor to the single-cycle CPU register file. It provides a general register array with two combinational read ports and one synchronous write port, plus a HI/LO pair. Write-to-read bypass is configurable. An IDLE/BUSY handshake lets a multi-cycle mult/div unit own HI/LO between issue and completion, and the block raises a stall while HI/LO reads are unsafe. It sits in the decode stage between control/decoder and ALU/mult-div.

Parameters:
DATA_W, 32, width of every register and data port
ADDR_W, 5, register address width; array depth = 2**ADDR_W
ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes
BYPASS, 1, 1 = same-cycle write data forwarded to matching read port

Ports:
CLK  in  1  clock, all state updates on rising edge
RST_N  in  1  asynchronous active-low reset
rs  in  ADDR_W  read address, port A
rt  in  ADDR_W  read address, port B
rs_sel  in  2  port A source: 00 GPR[rs], 01 HI, 10 LO, 11 GPR[rs]
regWrite  in  1  write enable
w_sel  in  2  write target: 00 GPR[WAddr], 01 HI (mthi), 10 LO (mtlo), 11 none
WAddr  in  ADDR_W  GPR write address
WData  in  DATA_W  write data
hilo_issue  in  1  mult/div issued this cycle
hilo_wvalid  in  1  mult/div result valid
Whi  in  DATA_W  result for HI
Wlo  in  DATA_W  result for LO
hilo_wready  out  1  result accepted when high together with hilo_wvalid
rsData  out  DATA_W  port A read data
rtData  out  DATA_W  port B read data (always GPR[rt])
hilo_busy  out  1  FSM in BUSY
stall  out  1  port A requests HI/LO while the value is not final
hilo_err  out  1  sticky protocol-error flag

Behaviour:
- Reset (async, RST_N=0): all GPRs, HI and LO cleared to 0; FSM to IDLE; hilo_err=0. hilo_busy=0, hilo_wready=0, stall=0, rsData/rtData=0.
- Reads are combinational with zero latency. GPR writes take effect at the rising edge of CLK when regWrite=1 and w_sel=00.
- ZERO_REG=1: a write to address 0 is dropped, and reads of address 0 return 0 even if bypass matches.
- BYPASS=1: if regWrite=1, w_sel=00, WAddr==rs (rs_sel GPR) and the address is nonzero or ZERO_REG=0, rsData=WData in the same cycle. The same rule applies to rt/rtData.
- Port A HI/LO bypass: a completing result (hilo_wvalid & hilo_wready) forwards Whi/Wlo. A legal mthi/mtlo forwards WData.
- BYPASS=0: reads return the pre-edge array contents.
- FSM IDLE:
  - hilo_issue=1 moves to BUSY.
  - hilo_wready=0. hilo_wvalid=1 sets hilo_err and is otherwise ignored.
  - mthi/mtlo write HI/LO normally.
- FSM BUSY:
  - hilo_wready=1, hilo_busy=1.
  - hilo_wvalid=1 writes HI<=Whi and LO<=Wlo at the edge. The FSM returns to IDLE, or stays BUSY if hilo_issue=1 in the same cycle (back-to-back).
  - hilo_issue without hilo_wvalid sets hilo_err; the FSM stays BUSY with no second pending op.
  - A mthi/mtlo write is dropped and sets hilo_err.
- stall = hilo_busy & (rs_sel==01 | rs_sel==10) & ~(hilo_wvalid & BYPASS). With BYPASS=0, stall stays high through the completion cycle.
- Simultaneous GPR write and HI/LO completion: both commit, since they use independent storage.
- hilo_err clears only on reset.
- Reset asserted mid-BUSY: the pending result is discarded, the FSM goes to IDLE, and HI/LO read 0.

Test Plan:
- Reset then write GPR[3]=0xDEADBEEF, next cycle rs=3 -> rsData=0xDEADBEEF. Write GPR[0]=0x1234 -> rs=0 reads 0.
- BYPASS=1: regWrite, WAddr=7, WData=0x55AA55AA, rs=rt=7 in the same cycle -> rsData=rtData=0x55AA55AA. With BYPASS=0 -> old value 0.
- hilo_issue, 3 idle cycles, then hilo_wvalid with Whi=0x1, Wlo=0xFFFFFFFE. Read HI on each of those cycles -> stall=1 for 3 cycles and 0 on the completion cycle (BYPASS=1). After completion, HI=1 and LO=0xFFFFFFFE, hilo_busy=0.
- Completion plus hilo_issue in the same cycle -> hilo_busy stays 1 and the results are committed. A later mtlo while BUSY is dropped, hilo_err=1, and LO is unchanged.
- In IDLE, hilo_wvalid=1 -> hilo_wready=0, HI/LO unchanged, hilo_err=1.
- Assert RST_N=0 mid-BUSY, asynchronously between edges -> hilo_busy, stall and hilo_err fall immediately, and HI/LO read 0 after release.
